// File: rtl/seq_booth_multiplier.sv
// Sequential N x N multiplier with start/busy/done handshake.
// Signed operations use radix-2 Booth recoding, unsigned ones use shift-add.
// One step per clock, fixed latency of N cycles; AQ only changes on completion.
module seq_booth_multiplier #(
    parameter int N         = 8,
    parameter bit SIGNED_EN = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   M,
    input  logic [N-1:0]   Qin,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] AQ
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [N:0]    a, a_sum, a_nx;
    logic [N-1:0]  q, q_nx, m_reg;
    logic          q_m1, q_m1_nx, mode;
    logic [CW-1:0] count;
    logic          accept, last;
    logic [N:0]    m_sx, m_zx;

    // A is one bit wider than M so that subtracting -2^(N-1) and the
    // unsigned carry-out are both held exactly.
    assign m_sx = {m_reg[N-1], m_reg};
    assign m_zx = {1'b0, m_reg};

    // One multiply step: conditional add/subtract, then right shift of {A,Q,q_m1}.
    always_comb begin
        a_sum = a;
        if (mode) begin
            case ({q[0], q_m1})
                2'b01:   a_sum = a + m_sx;
                2'b10:   a_sum = a - m_sx;
                default: a_sum = a;
            endcase
        end else if (q[0]) begin
            a_sum = a + m_zx;
        end
        a_nx    = {mode ? a_sum[N] : 1'b0, a_sum[N:1]};
        q_nx    = {a_sum[0], q[N-1:1]};
        q_m1_nx = q[0];
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and handshake outputs; start is only honoured in IDLE/DONE.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, step while running, publish on the last step.
    always_ff @(posedge clock) begin
        if (reset) begin
            a     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            m_reg <= '0;
            mode  <= 1'b0;
            AQ    <= '0;
        end else if (accept) begin
            a     <= '0;
            q     <= Qin;
            q_m1  <= 1'b0;
            count <= CW'(N);
            m_reg <= M;
            mode  <= is_signed & SIGNED_EN;
        end else if (state == RUN) begin
            a     <= a_nx;
            q     <= q_nx;
            q_m1  <= q_m1_nx;
            count <= count - 1'b1;
            if (last) AQ <= {a_nx[N-1:0], q_nx};
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Bench for seq_booth_multiplier: N=8 instance for handshake/latency/reset
// behaviour, plus two N=4 instances (SIGNED_EN=1 and 0) driven together
// for an exhaustive operand sweep. Products come from plain integer math.
module tb_seq_booth_multiplier;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        rst8 = 1'b1, start8 = 1'b0, s8 = 1'b0;
    logic [7:0]  m8 = '0, q8 = '0;
    logic        busy8, done8;
    logic [15:0] aq8;
    logic [15:0] prev8 = '0;

    logic        rst4 = 1'b1, start4 = 1'b0, s4 = 1'b0;
    logic [3:0]  m4 = '0, q4 = '0;
    logic        busy4s, done4s, busy4u, done4u;
    logic [7:0]  aq4s, aq4u;

    logic [7:0]  cm [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [7:0]  cq [3] = '{8'h80, 8'h01, 8'h80};
    logic [15:0] ces[3] = '{16'h4000, 16'hFFFF, 16'hC080};
    logic [15:0] ceu[3] = '{16'h4000, 16'h00FF, 16'h3F80};

    seq_booth_multiplier #(.N(8), .SIGNED_EN(1)) u8 (
        .clock(clk), .reset(rst8), .start(start8), .is_signed(s8),
        .M(m8), .Qin(q8), .busy(busy8), .done(done8), .AQ(aq8));

    seq_booth_multiplier #(.N(4), .SIGNED_EN(1)) u4s (
        .clock(clk), .reset(rst4), .start(start4), .is_signed(s4),
        .M(m4), .Qin(q4), .busy(busy4s), .done(done4s), .AQ(aq4s));

    seq_booth_multiplier #(.N(4), .SIGNED_EN(0)) u4u (
        .clock(clk), .reset(rst4), .start(start4), .is_signed(s4),
        .M(m4), .Qin(q4), .busy(busy4u), .done(done4u), .AQ(aq4u));

    // Exact product of two n-bit operands, truncated to 2n bits.
    function automatic logic [15:0] ref_mul(int n, int m, int q, bit s);
        longint mi, qi, p, full;
        full = longint'(1) << n;
        mi = longint'(m) & (full - 1);
        qi = longint'(q) & (full - 1);
        if (s && mi >= (full >> 1)) mi = mi - full;
        if (s && qi >= (full >> 1)) qi = qi - full;
        p = mi * qi;
        return 16'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one N=8 operation (from IDLE or DONE), scramble the inputs while
    // it runs, and check busy/done timing and the final product.
    task automatic run_op8(input logic [7:0] m, input logic [7:0] q, input bit s, input bit hold);
        logic [15:0] exp;
        exp = ref_mul(8, m, q, s);
        m8 = m; q8 = q; s8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = hold;
        for (int k = 1; k <= 8; k++) begin
            chk("busy8_run", 32'(busy8), 32'd1);
            chk("done8_run", 32'(done8), 32'd0);
            chk("aq8_hold", 32'(aq8), 32'(prev8));
            m8 = 8'($urandom); q8 = 8'($urandom); s8 = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("done8", 32'(done8), 32'd1);
        chk("busy8_off", 32'(busy8), 32'd0);
        chk("aq8", 32'(aq8), 32'(exp));
        prev8 = exp;
    endtask

    task automatic idle8();
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("idle8_busy", 32'(busy8), 32'd0);
        chk("idle8_done", 32'(done8), 32'd0);
        chk("idle8_aq", 32'(aq8), 32'(prev8));
    endtask

    // One N=4 operation on both instances; the SIGNED_EN=0 one must stay unsigned.
    task automatic run_op4(input int m, input int q, input bit s);
        m4 = 4'(m); q4 = 4'(q); s4 = s; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("busy4", 32'(busy4s), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("done4s", 32'(done4s), 32'd1);
        chk("aq4s", 32'(aq4s), 32'(ref_mul(4, m, q, s)));
        chk("done4u", 32'(done4u), 32'd1);
        chk("aq4u", 32'(aq4u), 32'(ref_mul(4, m, q, 1'b0)));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b0; rst4 = 1'b0;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_aq8", 32'(aq8), 32'd0);
        chk("rst_aq4s", 32'(aq4s), 32'd0);
        chk("rst_aq4u", 32'(aq4u), 32'd0);

        // Unsigned full-scale and zero operand.
        run_op8(8'd255, 8'd255, 1'b0, 1'b0);
        chk("t1_fe01", 32'(aq8), 32'h0000FE01);
        idle8();
        run_op8(8'd0, 8'd200, 1'b0, 1'b0);
        chk("t1_zero", 32'(aq8), 32'd0);
        idle8();

        // Signed corner cases and the same operands unsigned.
        for (int i = 0; i < 3; i++) begin
            run_op8(cm[i], cq[i], 1'b1, 1'b0);
            chk("t2_signed", 32'(aq8), 32'(ces[i]));
            idle8();
            run_op8(cm[i], cq[i], 1'b0, 1'b0);
            chk("t2_unsigned", 32'(aq8), 32'(ceu[i]));
            idle8();
        end

        // start held high throughout: continuous back-to-back operations.
        for (int i = 0; i < 4; i++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        idle8();

        // Reset in the third RUN cycle aborts the operation.
        m8 = 8'd77; q8 = 8'd99; s8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        prev8 = '0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_aq", 32'(aq8), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("abort_nodone", 32'(done8), 32'd0);
            chk("abort_aq_hold", 32'(aq8), 32'd0);
        end
        run_op8(8'($urandom), 8'($urandom), 1'b1, 1'b0);
        idle8();

        // Back-to-back: start pulsed only in the DONE cycle.
        for (int i = 0; i < 3; i++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        idle8();

        // Random mix.
        for (int i = 0; i < 20; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(1, 0) == 1) idle8();
        end
        idle8();

        // Exhaustive N=4 sweep, both modes.
        for (int s = 0; s < 2; s++)
            for (int m = 0; m < 16; m++)
                for (int q = 0; q < 16; q++)
                    run_op4(m, q, 1'(s));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Parametrised sequential multiplier, the next generation of the team's 4-bit shift-add multiplier. It adds an explicit start/busy/done handshake, a synchronous reset, operand capture at start and a per-operation signed (radix-2 Booth) / unsigned (shift-add) mode select. It sits as a multi-cycle arithmetic unit beside the datapath and is driven by a controller that pulses start and waits for done.

Parameters:
N, 8, operand width in bits (N >= 2); result width is 2*N.
SIGNED_EN, 1, 1 = is_signed input honoured; 0 = is_signed ignored and all operations are unsigned.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE or DONE
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
M  in  N  multiplicand; captured with start
Qin  in  N  multiplier; captured with start
busy  out  1  high while an operation is in RUN
done  out  1  one-cycle pulse: AQ holds a new result
AQ  out  2*N  product register

Behaviour:
- Reset (reset=1 at a rising edge): state=IDLE; busy=0, done=0, AQ=0; internal A, Q, q_m1 and count cleared. Reset applies in any state, including mid-RUN. An aborted operation produces no done and no AQ update.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 -> capture M, Qin and mode (mode = is_signed & SIGNED_EN). Load A=0 (N+1 bits), Q=Qin, q_m1=0, count=N. Go to RUN; busy=1 from E0.
- RUN: one step per edge, edges E1..EN.
  - Signed step: inspect {Q[0], q_m1}. 01 -> A=A+sext(M); 10 -> A=A-sext(M); 00/11 -> no change. Then arithmetic right shift of {A,Q,q_m1} by 1.
  - Unsigned step: if Q[0]=1, A=A+zext(M) with the carry kept in A[N]. Then logical right shift of {A,Q} by 1.
  - count decrements each step.
  - On the step where count reaches 0 (edge EN): AQ <= final {A[N-1:0],Q}, computed combinationally from that step. Go to DONE; busy=0, done=1.
- Latency: exactly N cycles from the accepting edge to done high, for every operand pair and both modes.
- DONE: lasts exactly one cycle with done=1.
  - If start=1 in this cycle, a new operation is accepted as from IDLE (back-to-back, no bubble).
  - Otherwise go to IDLE.
- AQ is updated only at completion. During RUN and IDLE it holds the previous result; it never shows intermediate values.
- start while in RUN is ignored. Changes to M, Qin or is_signed after capture do not affect the running operation.
- Width rule: A is N+1 bits, so M = -2^(N-1) (subtract overflows N bits) and unsigned carry-out are exact. The 2*N-bit product is always exact: no truncation, no overflow flag.
- Zero operands take the same N cycles; no early termination.

Test Plan:
1. N=8, unsigned, M=255, Qin=255, start 1 cycle -> busy high 8 cycles; done pulses 1 cycle, 8 cycles after the accepting edge; AQ=16'hFE01. Also M=0, Qin=200 -> AQ=0 after the same 8 cycles.
2. N=8, signed corner cases -> AQ must match:
   - M=8'h80, Qin=8'h80 -> AQ=16'h4000
   - M=8'hFF, Qin=8'h01 -> AQ=16'hFFFF
   - M=8'h7F, Qin=8'h80 -> AQ=16'hC080
   - Same operands with is_signed=0 give 16'h4000, 16'h00FF, 16'h3F80.
3. Hold start high and change M/Qin every cycle during RUN -> exactly one done per accepted start; result equals the product of the operands captured at the accepting edge; AQ unchanged until done.
4. Assert reset for 1 cycle at the 3rd RUN cycle -> next cycle busy=0, done=0, AQ=0. No done follows. A later start runs normally.
5. Back-to-back: start asserted in the DONE cycle with new operands -> busy re-asserts the next cycle; second done exactly N cycles later; first AQ value held until then.
6. N=4, SIGNED_EN=1: exhaustive 256 operand pairs x both modes, checked against a reference product. Then SIGNED_EN=0 with is_signed=1 -> all results unsigned.
